// File: rtl/ahbl_uart_rx.sv
// AHB-Lite UART receiver: 8N1 framing, 16x oversampling, small receive FIFO.
// Firmware polls STATUS (or waits on irq) and pops received bytes from DATA.
module ahbl_uart_rx #(
  parameter int          FIFO_DEPTH       = 4,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        rx,
  output logic        irq
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_PRESC  = 2'd2;

  // ---------------------------------------------------------------------------
  // Bus address-phase capture
  // ---------------------------------------------------------------------------
  logic [1:0] addr_q, addr_d;
  logic       write_q, write_d;
  logic       valid_q, valid_d;

  // Latch the address phase; the following cycle is the data phase.
  always_comb begin
    valid_d = HSEL & HREADY & HTRANS[1];
    addr_d  = HADDR[3:2];
    write_d = HWRITE;
  end

  // Address-phase registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      valid_q <= 1'b0;
      addr_q  <= 2'd0;
      write_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end

  logic dp_rd, dp_wr;
  logic st_wr, pre_wr, pop_req;
  assign dp_rd   = valid_q & ~write_q;
  assign dp_wr   = valid_q & write_q;
  assign st_wr   = dp_wr & (addr_q == OFS_STATUS);
  assign pre_wr  = dp_wr & (addr_q == OFS_PRESC);
  assign pop_req = dp_rd & (addr_q == OFS_DATA);

  // ---------------------------------------------------------------------------
  // Prescaler / oversample tick
  // ---------------------------------------------------------------------------
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] div_q, div_d;
  logic        tick;

  assign tick = (div_q == prescale_q);

  // Tick divider; a PRESCALE write restarts it so the new rate starts cleanly.
  always_comb begin
    prescale_d = prescale_q;
    div_d      = tick ? 16'd0 : div_q + 16'd1;
    if (pre_wr) begin
      prescale_d = HWDATA[15:0];
      div_d      = 16'd0;
    end
  end

  // Prescaler registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      prescale_q <= DEFAULT_PRESCALE;
      div_q      <= 16'd0;
    end else begin
      prescale_q <= prescale_d;
      div_q      <= div_d;
    end
  end

  // ---------------------------------------------------------------------------
  // rx synchroniser (idle-high, so both stages reset to 1)
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;

  // Two-stage synchroniser chain.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

  // Synchroniser flops.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bitn_q, bitn_d;
  logic [7:0] shift_q, shift_d;
  logic       push_req;
  logic       ferr_set;

  // Frame sequencing: start is confirmed at mid-bit (8 ticks), then every
  // 16 ticks lands on the middle of the next data/stop bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitn_d   = bitn_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d = ST_START;
            cnt_d   = 4'd0;
          end
        end
        ST_START: begin
          if (cnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = ST_DATA;
              cnt_d   = 4'd0;
              bitn_d  = 3'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            cnt_d   = 4'd0;
            if (bitn_q == 3'd7) state_d = ST_STOP;
            else                bitn_d  = bitn_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_STOP: begin
          if (cnt_q == 4'd15) begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
            if (rx_s_q) push_req = 1'b1;
            else        ferr_set = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      bitn_q  <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty, full, push, pop, ovr_set;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  // A pop on an empty FIFO is a no-op; a push into a full FIFO only
  // succeeds if a pop frees a slot in the same cycle.
  assign pop     = pop_req & ~empty;
  assign push    = push_req & (~full | pop);
  assign ovr_set = push_req & full & ~pop;

  // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags (hardware set beats a simultaneous W1C)
  // ---------------------------------------------------------------------------
  logic overrun_q, overrun_d;
  logic frame_err_q, frame_err_d;

  // Flag next-state: set OR (held AND NOT cleared).
  always_comb begin
    overrun_d   = ovr_set  | (overrun_q   & ~(st_wr & HWDATA[2]));
    frame_err_d = ferr_set | (frame_err_q & ~(st_wr & HWDATA[3]));
  end

  // Flag registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------------
  logic [31:0] status_w;
  assign status_w = {28'd0, frame_err_q, overrun_q, full, ~empty};

  // Read data only during a valid read data phase, else 0.
  always_comb begin
    HRDATA = 32'd0;
    if (dp_rd) begin
      case (addr_q)
        OFS_DATA:   HRDATA = {24'd0, empty ? 8'd0 : mem_q[rd_ptr_q]};
        OFS_STATUS: HRDATA = status_w;
        OFS_PRESC:  HRDATA = {16'd0, prescale_q};
        default:    HRDATA = 32'd0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign irq       = ~empty | overrun_q | frame_err_q;

  // Bus bits the register map never looks at.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:16]};

endmodule

// File: tb/tb_ahbl_uart_rx.sv
// Randomised scoreboard bench for ahbl_uart_rx: a byte-queue model of the
// receiver predicts every bus read; a monitor checks HRDATA/irq/HREADYOUT.
module tb_ahbl_uart_rx;
  localparam int DEPTH = 4;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] HADDR = 32'd0;
  logic [1:0]  HTRANS = 2'd0;
  logic [2:0]  HSIZE = 3'd2;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HWDATA = 32'd0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        rx = 1'b1;
  logic        irq;

  ahbl_uart_rx #(.FIFO_DEPTH(DEPTH), .DEFAULT_PRESCALE(16'd0)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .rx(rx), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: received bytes, sticky flags, prescale.
  logic [7:0]  mq[$];
  bit          m_ovr, m_ferr;
  logic [15:0] m_pre = 16'd0;

  // Scoreboard.
  logic [31:0] exp_q[$];
  bit          irq_q[$];
  string       nm_q[$];
  bit          rd_dphase = 1'b0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] m_status();
    return {28'd0, m_ferr, m_ovr, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  function automatic bit m_irq();
    return (mq.size() != 0) || m_ovr || m_ferr;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic bus_rd(input logic [3:0] a, input string nm);
    logic [31:0] e;
    case (a)
      4'h0:    e = (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0;
      4'h4:    e = m_status();
      4'h8:    e = {16'd0, m_pre};
      default: e = 32'd0;
    endcase
    exp_q.push_back(e);
    irq_q.push_back(m_irq());
    nm_q.push_back(nm);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = {28'd0, a}; HWRITE = 1'b0;
    cyc(1);
    HSEL = 1'b0; HTRANS = 2'b00; rd_dphase = 1'b1;
    cyc(1);
    rd_dphase = 1'b0;
    if (a == 4'h0 && mq.size() != 0) mq.delete(0);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = {28'd0, a}; HWRITE = 1'b1;
    cyc(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    cyc(1);
    if (a == 4'h4) begin
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_ferr = 1'b0;
    end
    if (a == 4'h8) m_pre = d[15:0];
  endtask

  // One 8N1 frame at the model's current baud; model updated at frame end.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    int per;
    per = (int'(m_pre) + 1) * 16;
    rx = 1'b0;
    cyc(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(per);
    end
    rx = stop_ok;
    cyc(per);
    rx = 1'b1;
    if (!stop_ok)               m_ferr = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else                        m_ovr = 1'b1;
  endtask

  // Monitor: compare every read data phase against the queued expectation.
  always @(negedge HCLK) begin
    logic [31:0] e;
    bit          ei;
    string       n;
    if (rd_dphase) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: read seen with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        ei = irq_q.pop_front();
        n  = nm_q.pop_front();
        total++;
        if (HRDATA !== e) begin
          bad++;
          $display("FAIL %s: HRDATA got %08h want %08h", n, HRDATA, e);
        end
        total++;
        if (irq !== ei) begin
          bad++;
          $display("FAIL %s_irq: irq got %b want %b", n, irq, ei);
        end
        total++;
        if (HREADYOUT !== 1'b1) begin
          bad++;
          $display("FAIL %s_hreadyout: got %b want 1", n, HREADYOUT);
        end
      end
    end
  end

  initial begin
    int n;
    logic [7:0] rb;

    // Reset state.
    cyc(3);
    HRESET = 1'b0;
    cyc(2);
    bus_rd(4'h8, "rst_presc");
    bus_rd(4'h4, "rst_status");
    bus_rd(4'h0, "rst_data");

    // Single byte at fastest rate.
    send_byte(8'hA5, 1'b1);
    cyc(5);
    bus_rd(4'h4, "a5_status");
    bus_rd(4'h0, "a5_data");
    bus_rd(4'h4, "a5_status_after");

    // Overflow: five bytes into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    cyc(5);
    bus_rd(4'h4, "ovr_status");
    for (int i = 0; i < 5; i++) bus_rd(4'h0, "ovr_data");
    bus_wr(4'h4, 32'h4);
    bus_rd(4'h4, "ovr_cleared");

    // Framing error: stop bit held low.
    send_byte(8'h3C, 1'b0);
    cyc(40);
    bus_rd(4'h4, "ferr_status");
    bus_rd(4'h0, "ferr_data");
    bus_wr(4'h4, 32'h8);
    bus_rd(4'h4, "ferr_cleared");

    // Short low glitch is rejected as a false start.
    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(40);
    bus_rd(4'h4, "glitch_status");

    // Slower baud.
    bus_wr(4'h8, 32'h3);
    bus_rd(4'h8, "presc3");
    send_byte(8'h5A, 1'b1);
    cyc(10);
    bus_rd(4'h0, "slow_data");

    // Reset in the middle of bit 4 of a frame.
    rx = 1'b0;
    cyc(64);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(i % 2);
      cyc(64);
    end
    rx = 1'b0;
    cyc(32);
    HRESET = 1'b1;
    cyc(2);
    rx = 1'b1;
    HRESET = 1'b0;
    mq.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_pre = 16'd0;
    cyc(10);
    send_byte(8'h81, 1'b1);
    cyc(5);
    bus_rd(4'h4, "rstmid_status");
    bus_rd(4'h0, "rstmid_data");
    bus_rd(4'h4, "rstmid_status_after");
    bus_rd(4'hC, "reserved");

    // Randomised bursts at random baud.
    for (int r = 0; r < 6; r++) begin
      bus_wr(4'h8, {16'd0, 16'($urandom_range(0, 2))});
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        rb = 8'($urandom);
        send_byte(rb, 1'b1);
      end
      cyc(8);
      bus_rd(4'h4, "rnd_status");
      for (int k = 0; k <= n; k++) bus_rd(4'h0, "rnd_data");
      bus_wr(4'h4, 32'hC);
      bus_rd(4'h4, "rnd_status_clr");
    end

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
